// File: rtl/fazyrv_ccx_pkg.sv
// Shared types and constants for the chunk-serial CCX responder.
// Holds no logic, so it has no latency or backpressure of its own.
package fazyrv_ccx_pkg;

  localparam int unsigned CCX_WORDW = 32;

  typedef enum logic [1:0] {
    MINU = 2'b00,
    MAXU = 2'b01,
    HAMM = 2'b10,
    BREV = 2'b11
  } ccx_sel_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    STREAM,
    WAIT_LOW
  } ccx_state_e;

endpackage

// File: rtl/fazyrv_ccx_alu.sv
// CCX operation unit: 32-bit MINU/MAXU/popcount(A^B)/bit-reverse(A), purely combinational.
// It has zero latency and no backpressure; the operands are held stable by the caller.
module fazyrv_ccx_alu
  import fazyrv_ccx_pkg::*;
(
  input  ccx_sel_e              sel,
  input  logic [CCX_WORDW-1:0]  a,
  input  logic [CCX_WORDW-1:0]  b,
  output logic [CCX_WORDW-1:0]  res
);

  logic [CCX_WORDW-1:0] diff;
  logic [CCX_WORDW-1:0] brev;
  logic [5:0]           pop;

  always_comb begin
    diff = a ^ b;
    pop  = '0;
    brev = '0;
    for (int i = 0; i < CCX_WORDW; i++) begin
      pop               = pop + 6'(diff[i]);
      brev[CCX_WORDW-1-i] = a[i];
    end
  end

  always_comb begin
    res = '0;
    unique case (sel)
      MINU:    res = (a < b) ? a : b;
      MAXU:    res = (a > b) ? a : b;
      HAMM:    res = {{(CCX_WORDW-6){1'b0}}, pop};
      BREV:    res = brev;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/fazyrv_ccx_resp.sv
// CCX responder: deserialises A/B chunks, evaluates, and streams the result; resp at cycle N+1+EXTRA_LAT.
// No backpressure: the core holds ccx_req_i for the whole transaction, and dropping it during LOAD aborts.
module fazyrv_ccx_resp
  import fazyrv_ccx_pkg::*;
#(
  parameter int unsigned CHUNKSIZE = 8,
  parameter int unsigned EXTRA_LAT = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ccx_req_i,
  input  logic [1:0]           ccx_sel_i,
  input  logic [CHUNKSIZE-1:0] ccx_rs_a_i,
  input  logic [CHUNKSIZE-1:0] ccx_rs_b_i,
  output logic [CHUNKSIZE-1:0] ccx_res_o,
  output logic                 ccx_resp_o
);

  localparam int unsigned N = CCX_WORDW / CHUNKSIZE;
  localparam logic [5:0] LOAD_LAST  = 6'(N - 1);
  localparam logic [5:0] STREAM_END = 6'(N);
  localparam logic [5:0] LAT_LAST   = 6'(EXTRA_LAT);

  ccx_state_e           state_q;
  ccx_sel_e             sel_q;
  logic [5:0]           cnt_q;
  logic [CCX_WORDW-1:0] a_q;
  logic [CCX_WORDW-1:0] b_q;
  logic [CCX_WORDW-1:0] res_q;
  logic [CCX_WORDW-1:0] alu_res;

  fazyrv_ccx_alu u_alu (
    .sel (sel_q),
    .a   (a_q),
    .b   (b_q),
    .res (alu_res)
  );

  // Operands shift in from the top so chunk k lands at bits [k*CHUNKSIZE +: CHUNKSIZE] after N shifts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sel_q      <= MINU;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      ccx_res_o  <= '0;
      ccx_resp_o <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ccx_res_o  <= '0;
          ccx_resp_o <= 1'b0;
          if (ccx_req_i) begin
            sel_q   <= ccx_sel_e'(ccx_sel_i);
            a_q     <= {ccx_rs_a_i, a_q[CCX_WORDW-1:CHUNKSIZE]};
            b_q     <= {ccx_rs_b_i, b_q[CCX_WORDW-1:CHUNKSIZE]};
            cnt_q   <= 6'd1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (!ccx_req_i) begin
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            a_q <= {ccx_rs_a_i, a_q[CCX_WORDW-1:CHUNKSIZE]};
            b_q <= {ccx_rs_b_i, b_q[CCX_WORDW-1:CHUNKSIZE]};
            if (cnt_q == LOAD_LAST) begin
              cnt_q   <= '0;
              state_q <= COMPUTE;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        COMPUTE: begin
          if (cnt_q == LAT_LAST) begin
            res_q      <= alu_res >> CHUNKSIZE;
            ccx_res_o  <= alu_res[CHUNKSIZE-1:0];
            ccx_resp_o <= 1'b1;
            cnt_q      <= 6'd1;
            state_q    <= STREAM;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        STREAM: begin
          ccx_resp_o <= 1'b0;
          if (cnt_q == STREAM_END) begin
            ccx_res_o <= '0;
            cnt_q     <= '0;
            state_q   <= WAIT_LOW;
          end else begin
            ccx_res_o <= res_q[CHUNKSIZE-1:0];
            res_q     <= res_q >> CHUNKSIZE;
            cnt_q     <= cnt_q + 6'd1;
          end
        end
        WAIT_LOW: begin
          ccx_res_o  <= '0;
          ccx_resp_o <= 1'b0;
          if (!ccx_req_i) state_q <= IDLE;
        end
        default: begin
          ccx_res_o  <= '0;
          ccx_resp_o <= 1'b0;
          cnt_q      <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fazyrv_ccx_resp.sv
// Bench for the CCX responder at CHUNKSIZE 8 (no extra latency) and CHUNKSIZE 1 (EXTRA_LAT 3).
module tb_fazyrv_ccx_resp;

  logic       clk = 1'b0;
  logic       rst;
  logic       req8, resp8;
  logic [1:0] sel8;
  logic [7:0] a8, b8, res8;
  logic       req1, resp1;
  logic [1:0] sel1;
  logic [0:0] a1, b1, res1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fazyrv_ccx_resp #(.CHUNKSIZE(8), .EXTRA_LAT(0)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .ccx_req_i(req8), .ccx_sel_i(sel8),
    .ccx_rs_a_i(a8), .ccx_rs_b_i(b8), .ccx_res_o(res8), .ccx_resp_o(resp8)
  );

  fazyrv_ccx_resp #(.CHUNKSIZE(1), .EXTRA_LAT(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .ccx_req_i(req1), .ccx_sel_i(sel1),
    .ccx_rs_a_i(a1), .ccx_rs_b_i(b1), .ccx_res_o(res1), .ccx_resp_o(resp1)
  );

  function automatic logic [31:0] model(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (sel)
      2'd0: r = (a < b) ? a : b;
      2'd1: r = (a > b) ? a : b;
      2'd2: r = 32'($countones(a ^ b));
      default: for (int i = 0; i < 32; i++) r[31-i] = a[i];
    endcase
    return r;
  endfunction

  task automatic drive_chunk(input bit big, input logic req, input logic [1:0] sel,
                             input logic [31:0] a, input logic [31:0] b, input int c);
    logic [31:0] sa, sb;
    if (big) begin
      sa = a >> (c * 8);
      sb = b >> (c * 8);
      req8 = req; sel8 = sel; a8 = sa[7:0]; b8 = sb[7:0];
    end else begin
      sa = a >> c;
      sb = b >> c;
      req1 = req; sel1 = sel; a1 = sa[0]; b1 = sb[0];
    end
  endtask

  // Drives one transaction from cycle 0 and records what the responder streamed back.
  task automatic run_txn(input bit big, input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input int abort_at, input int hold,
                         output logic [31:0] got, output int resp_cyc, output int pulses, output int stray);
    int n, cs, extra, total;
    logic [7:0] r;
    logic p;
    n = big ? 4 : 32;
    cs = big ? 8 : 1;
    extra = big ? 0 : 3;
    total = 2 * n + extra + 4 + hold;
    got = '0; resp_cyc = -1; pulses = 0; stray = 0;
    @(negedge clk);
    drive_chunk(big, 1'b1, sel, a, b, 0);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (big) begin r = res8; p = resp8; end
      else begin r = {7'b0, res1}; p = resp1; end
      if (p) begin
        pulses++;
        if (resp_cyc < 0) resp_cyc = c;
      end
      if (resp_cyc >= 0 && (c - resp_cyc) < n) got = got | (32'(r) << ((c - resp_cyc) * cs));
      else if (r != 0) stray++;
      drive_chunk(big, ((abort_at < 0) || (c < abort_at)) && (c < total - 2), sel, a, b, c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (res8 !== 8'h00) begin fails++; $display("FAIL reset_res8 got=%h exp=00", res8); end
    tests++; if (resp8 !== 1'b0) begin fails++; $display("FAIL reset_resp8 got=%b exp=0", resp8); end
    tests++; if (res1 !== 1'b0) begin fails++; $display("FAIL reset_res1 got=%b exp=0", res1); end
    tests++; if (resp1 !== 1'b0) begin fails++; $display("FAIL reset_resp1 got=%b exp=0", resp1); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  sels [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [31:0] as   [4] = '{32'h00001234, 32'h80000000, 32'hFFFFFFFF, 32'h00000001};
    logic [31:0] bs   [4] = '{32'h000000FF, 32'h7FFFFFFF, 32'h00000000, 32'h12345678};
    logic [31:0] exps [4] = '{32'h000000FF, 32'h80000000, 32'h00000020, 32'h80000000};
    logic [31:0] got;
    int rc, pl, st;
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, sels[i], as[i], bs[i], -1, 0, got, rc, pl, st);
      tests++; if (got !== exps[i]) begin fails++; $display("FAIL directed%0d_result got=%h exp=%h", i, got, exps[i]); end
      tests++; if (rc != 5) begin fails++; $display("FAIL directed%0d_resp_cycle got=%0d exp=5", i, rc); end
      tests++; if (pl != 1) begin fails++; $display("FAIL directed%0d_pulses got=%0d exp=1", i, pl); end
      tests++; if (st != 0) begin fails++; $display("FAIL directed%0d_res_outside_stream got=%0d exp=0", i, st); end
    end
  endtask

  task automatic test_abort_then_full();
    logic [31:0] got;
    int rc, pl, st;
    run_txn(1'b1, 2'd1, 32'hDEADBEEF, 32'h11111111, 3, 0, got, rc, pl, st);
    tests++; if (pl != 0) begin fails++; $display("FAIL abort_pulses got=%0d exp=0", pl); end
    tests++; if (st != 0) begin fails++; $display("FAIL abort_res_nonzero got=%0d exp=0", st); end
    run_txn(1'b1, 2'd0, 32'd5, 32'd3, -1, 0, got, rc, pl, st);
    tests++; if (got !== 32'd3) begin fails++; $display("FAIL after_abort_result got=%h exp=00000003", got); end
    tests++; if (rc != 5) begin fails++; $display("FAIL after_abort_resp_cycle got=%0d exp=5", rc); end
  endtask

  task automatic test_hold_high();
    logic [31:0] got;
    int rc, pl, st;
    run_txn(1'b1, 2'd2, 32'h0F0F0F0F, 32'h00FF00FF, -1, 8, got, rc, pl, st);
    tests++; if (pl != 1) begin fails++; $display("FAIL hold_pulses got=%0d exp=1", pl); end
    tests++; if (got !== 32'd16) begin fails++; $display("FAIL hold_result got=%h exp=00000010", got); end
    tests++; if (st != 0) begin fails++; $display("FAIL hold_res_outside_stream got=%0d exp=0", st); end
  endtask

  task automatic test_reset_mid_stream();
    bit found;
    int bad;
    logic [31:0] got;
    int rc, pl, st;
    found = 0;
    bad = 0;
    @(negedge clk);
    drive_chunk(1'b1, 1'b1, 2'd3, 32'hFFFFFFFF, 32'h0, 0);
    for (int c = 1; c < 20 && !found; c++) begin
      @(negedge clk);
      if (resp8) found = 1;
      drive_chunk(1'b1, 1'b1, 2'd3, 32'hFFFFFFFF, 32'h0, c);
    end
    tests++; if (!found) begin fails++; $display("FAIL midrst_resp_timeout got=0 exp=1"); end
    @(negedge clk);
    rst = 1'b1;
    req8 = 1'b0;
    @(negedge clk);
    tests++; if (res8 !== 8'h00) begin fails++; $display("FAIL midrst_res got=%h exp=00", res8); end
    tests++; if (resp8 !== 1'b0) begin fails++; $display("FAIL midrst_resp got=%b exp=0", resp8); end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (res8 !== 8'h00 || resp8 !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL midrst_idle_outputs got=%0d exp=0", bad); end
    run_txn(1'b1, 2'd1, 32'h00000010, 32'h00000020, -1, 0, got, rc, pl, st);
    tests++; if (got !== 32'h20 || rc != 5) begin fails++; $display("FAIL midrst_recover got=%h@%0d exp=00000020@5", got, rc); end
  endtask

  task automatic test_chunk1();
    logic [31:0] got;
    int rc, pl, st;
    run_txn(1'b0, 2'd3, 32'h0000000F, 32'h0, -1, 0, got, rc, pl, st);
    tests++; if (got !== 32'hF0000000) begin fails++; $display("FAIL cs1_brev got=%h exp=f0000000", got); end
    tests++; if (rc != 36) begin fails++; $display("FAIL cs1_resp_cycle got=%0d exp=36", rc); end
    tests++; if (pl != 1) begin fails++; $display("FAIL cs1_pulses got=%0d exp=1", pl); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp, got;
    logic [1:0] sel;
    int rc, pl, st;
    for (int i = 0; i < 20; i++) begin
      bit big;
      big = (i < 17);
      sel = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 5 == 0) ? a : ((i % 5 == 1) ? a ^ (32'h1 << $urandom_range(0, 31)) : $urandom);
      exp = model(sel, a, b);
      run_txn(big, sel, a, b, -1, 0, got, rc, pl, st);
      tests++; if (got !== exp) begin fails++; $display("FAIL rand%0d_result sel=%0d a=%h b=%h got=%h exp=%h", i, sel, a, b, got, exp); end
      tests++; if (rc != (big ? 5 : 36) || pl != 1) begin fails++; $display("FAIL rand%0d_timing got=%0d/%0d exp=%0d/1", i, rc, pl, big ? 5 : 36); end
    end
  endtask

  initial begin
    rst = 1'b1;
    req8 = 1'b0; sel8 = '0; a8 = '0; b8 = '0;
    req1 = 1'b0; sel1 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_directed();
    test_abort_then_full();
    test_hold_high();
    test_reset_mid_stream();
    test_chunk1();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
